// File: rtl/regfile_param_if.sv
// regfile_param_if: bus bundle between the register file and its users.
//   master : decode/writeback side (drives write ports, read/debug addresses, clear request)
//   slave  : register file side (returns read data, debug data and clear/conflict status)
// Ports carried:
//   we_a/wa_a/wd_a  write port A        we_b/wa_b/wd_b  write port B (priority)
//   ra1/ra2         read addresses      rd1/rd2         read data
//   dbg_sel         debug address       dbg_data        debug read data (stored value)
//   clr_req         clear request       clr_busy/clr_done clear status
//   wr_conflict     same-address dual write seen on the previous cycle
interface regfile_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              we_a;
  logic [ADDR_W-1:0] wa_a;
  logic [DATA_W-1:0] wd_a;
  logic              we_b;
  logic [ADDR_W-1:0] wa_b;
  logic [DATA_W-1:0] wd_b;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [ADDR_W-1:0] dbg_sel;
  logic [DATA_W-1:0] dbg_data;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;
  logic              wr_conflict;

  modport master (
    output we_a, wa_a, wd_a, we_b, wa_b, wd_b, ra1, ra2, dbg_sel, clr_req,
    input  rd1, rd2, dbg_data, clr_busy, clr_done, wr_conflict
  );

  modport slave (
    input  we_a, wa_a, wd_a, we_b, wa_b, wd_b, ra1, ra2, dbg_sel, clr_req,
    output rd1, rd2, dbg_data, clr_busy, clr_done, wr_conflict
  );
endinterface

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file, two write ports (B has priority),
// optional same-cycle write-to-read bypass, optional hardwired-zero register 0,
// and a sequenced clear engine that zeroes one register per cycle.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  regfile_param_if.slave (write ports, read ports, debug port, clear control,
//        wr_conflict status)
module regfile_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic            clk,
  input logic            rst,
  regfile_param_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  // One extra bit so the terminal index DEPTH-1 and the wrapped value never alias.
  localparam int IDX_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem_r [DEPTH];
  state_t            state_r;
  state_t            state_s;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  idx_s;
  logic              busy_r;
  logic              done_r;
  logic              conflict_r;
  logic              eff_a_s;
  logic              eff_b_s;
  logic              conflict_s;
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;
  logic [DATA_W-1:0] dbg_s;

  // True when addr is the hardwired-zero register.
  function automatic logic zero_hit(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
  endfunction

  // Read mux shared by rd1/rd2: zero register, then bypass (B over A), then storage.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              eff_a,
    input logic [ADDR_W-1:0] wa_a,
    input logic [DATA_W-1:0] wd_a,
    input logic              eff_b,
    input logic [ADDR_W-1:0] wa_b,
    input logic [DATA_W-1:0] wd_b
  );
    logic [DATA_W-1:0] val;
    if (zero_hit(addr)) begin
      val = {DATA_W{1'b0}};
    end else if ((BYPASS != 0) && eff_b && (wa_b == addr)) begin
      val = wd_b;
    end else if ((BYPASS != 0) && eff_a && (wa_a == addr)) begin
      val = wd_a;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Effective writes: blocked while clearing and on the zero register.
  always_comb begin
    eff_a_s    = bus.we_a && !busy_r && !zero_hit(bus.wa_a);
    eff_b_s    = bus.we_b && !busy_r && !zero_hit(bus.wa_b);
    conflict_s = eff_a_s && eff_b_s && (bus.wa_a == bus.wa_b);
  end

  // Register storage: clear engine owns the bank while busy, otherwise A then B (B wins).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (busy_r) begin
      mem_r[idx_r[ADDR_W-1:0]] <= {DATA_W{1'b0}};
    end else begin
      if (eff_a_s) begin
        mem_r[bus.wa_a] <= bus.wd_a;
      end
      if (eff_b_s) begin
        mem_r[bus.wa_b] <= bus.wd_b;
      end
    end
  end

  // Clear FSM next-state and index logic.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (bus.clr_req) begin
          state_s = CLEAR;
          idx_s   = {IDX_W{1'b0}};
        end else begin
          state_s = IDLE;
          idx_s   = idx_r;
        end
      end
      CLEAR: begin
        idx_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
        if (idx_r == IDX_W'(DEPTH - 1)) begin
          state_s = DONE;
        end else begin
          state_s = CLEAR;
        end
      end
      DONE: begin
        state_s = IDLE;
        idx_s   = idx_r;
      end
      default: begin
        state_s = IDLE;
        idx_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // FSM state, index and registered status outputs (decoded from next state).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      idx_r      <= {IDX_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      conflict_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      busy_r     <= (state_s == CLEAR);
      done_r     <= (state_s == DONE);
      conflict_r <= conflict_s;
    end
  end

  // Read ports; bypass only applies to effective writes, so never during clear.
  always_comb begin
    rd1_s = read_port(bus.ra1, mem_r[bus.ra1], eff_a_s, bus.wa_a, bus.wd_a,
                      eff_b_s, bus.wa_b, bus.wd_b);
    rd2_s = read_port(bus.ra2, mem_r[bus.ra2], eff_a_s, bus.wa_a, bus.wd_a,
                      eff_b_s, bus.wa_b, bus.wd_b);
    if (zero_hit(bus.dbg_sel)) begin
      dbg_s = {DATA_W{1'b0}};
    end else begin
      dbg_s = mem_r[bus.dbg_sel];
    end
  end

  assign bus.rd1         = rd1_s;
  assign bus.rd2         = rd2_s;
  assign bus.dbg_data    = dbg_s;
  assign bus.clr_busy    = busy_r;
  assign bus.clr_done    = done_r;
  assign bus.wr_conflict = conflict_r;

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed bench for regfile_param. Two instances share stimulus:
// dut (BYPASS=1) and dut_nb (BYPASS=0), both with ZERO_REG=1. Stimulus pushes
// expected values tagged with the current cycle; a negedge monitor pops and compares.
module tb_regfile_param;

  localparam int SIG_RD1  = 0;
  localparam int SIG_RD2  = 1;
  localparam int SIG_DBG  = 2;
  localparam int SIG_BUSY = 3;
  localparam int SIG_DONE = 4;
  localparam int SIG_CONF = 5;
  localparam int SIG_RD1N = 6;

  typedef struct {
    int         cyc;
    int         sig;
    logic [7:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we_a, we_b, clr_req;
  logic [2:0] wa_a, wa_b, ra1, ra2, dbg_sel;
  logic [7:0] wd_a, wd_b;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       q[$];

  regfile_param_if #(.DATA_W(8), .ADDR_W(3)) bus0 ();
  regfile_param_if #(.DATA_W(8), .ADDR_W(3)) bus1 ();

  assign bus0.we_a = we_a;  assign bus1.we_a = we_a;
  assign bus0.wa_a = wa_a;  assign bus1.wa_a = wa_a;
  assign bus0.wd_a = wd_a;  assign bus1.wd_a = wd_a;
  assign bus0.we_b = we_b;  assign bus1.we_b = we_b;
  assign bus0.wa_b = wa_b;  assign bus1.wa_b = wa_b;
  assign bus0.wd_b = wd_b;  assign bus1.wd_b = wd_b;
  assign bus0.ra1 = ra1;    assign bus1.ra1 = ra1;
  assign bus0.ra2 = ra2;    assign bus1.ra2 = ra2;
  assign bus0.dbg_sel = dbg_sel;  assign bus1.dbg_sel = dbg_sel;
  assign bus0.clr_req = clr_req;  assign bus1.clr_req = clr_req;

  regfile_param #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  regfile_param #(.DATA_W(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged for this cycle.
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] act;
    string      nm;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      case (e.sig)
        SIG_RD1:  begin act = bus0.rd1;                nm = "rd1"; end
        SIG_RD2:  begin act = bus0.rd2;                nm = "rd2"; end
        SIG_DBG:  begin act = bus0.dbg_data;           nm = "dbg_data"; end
        SIG_BUSY: begin act = {7'd0, bus0.clr_busy};    nm = "clr_busy"; end
        SIG_DONE: begin act = {7'd0, bus0.clr_done};    nm = "clr_done"; end
        SIG_CONF: begin act = {7'd0, bus0.wr_conflict}; nm = "wr_conflict"; end
        SIG_RD1N: begin act = bus1.rd1;                nm = "rd1_nobypass"; end
        default:  begin act = 8'hxx;                   nm = "unknown"; end
      endcase
      if (e.cyc != cyc || act !== e.val) begin
        errors++;
        $display("FAIL %s cyc=%0d actual=%h required=%h", nm, e.cyc, act, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_a = 1'b0; we_b = 1'b0; clr_req = 1'b0;
  endtask

  task automatic chk(input int sig, input logic [7:0] v);
    exp_t e;
    e.cyc = cyc; e.sig = sig; e.val = v;
    q.push_back(e);
  endtask

  initial begin
    idle();
    wa_a = 3'd0; wd_a = 8'h00; wa_b = 3'd0; wd_b = 8'h00;
    ra1 = 3'd1; ra2 = 3'd2; dbg_sel = 3'd2;

    // Reset state.
    step();
    chk(SIG_RD1, 8'h00); chk(SIG_RD2, 8'h00); chk(SIG_DBG, 8'h00);
    chk(SIG_BUSY, 8'h00); chk(SIG_DONE, 8'h00); chk(SIG_CONF, 8'h00);

    // Dual write, different addresses; bypass visible on dut only.
    step(); rst = 1'b1;
    we_a = 1'b1; wa_a = 3'd1; wd_a = 8'h5A;
    we_b = 1'b1; wa_b = 3'd2; wd_b = 8'hA5;
    chk(SIG_RD1, 8'h5A); chk(SIG_RD2, 8'hA5); chk(SIG_RD1N, 8'h00); chk(SIG_DBG, 8'h00);
    step(); idle();
    chk(SIG_RD1, 8'h5A); chk(SIG_RD2, 8'hA5); chk(SIG_DBG, 8'hA5);
    chk(SIG_RD1N, 8'h5A); chk(SIG_CONF, 8'h00);

    // Same-address conflict: B wins, flag one cycle later for one cycle.
    step(); ra1 = 3'd3;
    we_a = 1'b1; wa_a = 3'd3; wd_a = 8'h11;
    we_b = 1'b1; wa_b = 3'd3; wd_b = 8'h22;
    chk(SIG_RD1, 8'h22); chk(SIG_RD1N, 8'h00); chk(SIG_CONF, 8'h00);
    step(); idle();
    chk(SIG_RD1, 8'h22); chk(SIG_RD1N, 8'h22); chk(SIG_CONF, 8'h01);
    step();
    chk(SIG_CONF, 8'h00);

    // Bypass: A then B to x4.
    step(); ra1 = 3'd4; dbg_sel = 3'd4;
    we_a = 1'b1; wa_a = 3'd4; wd_a = 8'h07;
    chk(SIG_RD1, 8'h07); chk(SIG_RD1N, 8'h00);
    step(); idle();
    we_b = 1'b1; wa_b = 3'd4; wd_b = 8'h99;
    chk(SIG_RD1, 8'h99); chk(SIG_RD1N, 8'h07); chk(SIG_DBG, 8'h07);
    step(); idle();
    chk(SIG_RD1, 8'h99); chk(SIG_RD1N, 8'h99); chk(SIG_DBG, 8'h99);

    // Zero register: writes ignored, no conflict.
    step(); ra1 = 3'd0; ra2 = 3'd0; dbg_sel = 3'd0;
    we_a = 1'b1; wa_a = 3'd0; wd_a = 8'hFF;
    we_b = 1'b1; wa_b = 3'd0; wd_b = 8'h33;
    chk(SIG_RD1, 8'h00); chk(SIG_RD2, 8'h00); chk(SIG_RD1N, 8'h00); chk(SIG_DBG, 8'h00);
    step(); idle();
    chk(SIG_RD1, 8'h00); chk(SIG_CONF, 8'h00); chk(SIG_DBG, 8'h00);

    // Fill x1..x7 with 0x10+k.
    for (int k = 1; k < 8; k += 2) begin
      step(); idle();
      we_a = 1'b1; wa_a = 3'(k); wd_a = 8'(8'h10 + k);
      we_b = (k + 1 < 8); wa_b = 3'(k + 1); wd_b = 8'(8'h10 + k + 1);
    end
    step(); idle(); ra1 = 3'd5; ra2 = 3'd1; dbg_sel = 3'd7;
    chk(SIG_RD1, 8'h15); chk(SIG_RD2, 8'h11); chk(SIG_DBG, 8'h17);

    // Clear request sampled at the end of this cycle.
    step(); clr_req = 1'b1;
    chk(SIG_BUSY, 8'h00);
    for (int j = 1; j <= 8; j++) begin
      step(); idle(); clr_req = 1'b1;
      if (j == 4) begin
        we_a = 1'b1; wa_a = 3'd1; wd_a = 8'hEE;
        we_b = 1'b1; wa_b = 3'd1; wd_b = 8'hDD;
        chk(SIG_RD2, 8'h00);
      end else if (j == 5) begin
        chk(SIG_CONF, 8'h00);
      end else begin
        chk(SIG_DONE, 8'h00);
      end
      chk(SIG_BUSY, 8'h01);
      chk(SIG_RD1, (j <= 6) ? 8'h15 : 8'h00);
    end
    // DONE cycle: request still high but ignored; write here is accepted.
    step(); idle(); clr_req = 1'b1;
    we_a = 1'b1; wa_a = 3'd2; wd_a = 8'h77;
    chk(SIG_BUSY, 8'h00); chk(SIG_DONE, 8'h01);
    step(); idle(); ra1 = 3'd2; ra2 = 3'd1;
    chk(SIG_BUSY, 8'h00); chk(SIG_DONE, 8'h00);
    chk(SIG_RD1, 8'h77); chk(SIG_RD2, 8'h00);
    for (int k = 0; k < 8; k++) begin
      step(); dbg_sel = 3'(k);
      chk(SIG_DBG, (k == 2) ? 8'h77 : 8'h00);
    end

    // Reset mid-clear.
    step(); we_a = 1'b1; wa_a = 3'd5; wd_a = 8'h55;
    we_b = 1'b1; wa_b = 3'd6; wd_b = 8'h66;
    step(); idle(); clr_req = 1'b1; dbg_sel = 3'd5; ra1 = 3'd6;
    chk(SIG_DBG, 8'h55); chk(SIG_RD1, 8'h66);
    for (int j = 1; j <= 3; j++) begin
      step(); idle();
      chk(SIG_BUSY, 8'h01); chk(SIG_DBG, 8'h55);
    end
    step(); rst = 1'b0;
    chk(SIG_BUSY, 8'h00); chk(SIG_DONE, 8'h00); chk(SIG_DBG, 8'h00); chk(SIG_RD1, 8'h00);
    step(); rst = 1'b1;
    chk(SIG_BUSY, 8'h00);
    for (int j = 0; j < 10; j++) begin
      step();
      chk(SIG_DONE, 8'h00); chk(SIG_BUSY, 8'h00);
    end

    step();
    step();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file for the RISC-V datapath: generalised data width and depth, with two write ports, optional write-to-read bypass, and a sequenced clear engine. Drop-in successor for the 8×8 single-write bank. It sits between decode (read addresses) and writeback (write ports), and exposes a debug read port for the LCD/monitor path.

## Interface

- DATA_W, 8, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only
- ZERO_REG, 1, 1 = register 0 hardwired to zero (writes ignored, reads 0)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- we_a  in  1  write enable, port A
- wa_a  in  ADDR_W  write address, port A
- wd_a  in  DATA_W  write data, port A
- we_b  in  1  write enable, port B (priority port)
- wa_b  in  ADDR_W  write address, port B
- wd_b  in  DATA_W  write data, port B
- ra1, ra2  in  ADDR_W  read addresses
- rd1, rd2  out  DATA_W  combinational read data
- dbg_sel  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  stored value at dbg_sel (never bypassed)
- clr_req  in  1  request sequenced clear of all registers
- clr_busy  out  1  clear sequence in progress
- clr_done  out  1  one-cycle pulse when clear completes
- wr_conflict  out  1  registered flag: previous cycle had both ports writing the same effective address

## Operation

- Storage: DEPTH × DATA_W registers.
- Effective write: port X is effective when we_X=1, clr_busy=0, and not (ZERO_REG=1 and wa_X=0).
- A and B effective, different addresses: both registers update.
- A and B effective, same address: B's data is written and A's is dropped. wr_conflict=1 on the following cycle; otherwise wr_conflict=0.
- Reads (rd1/rd2):
  - ZERO_REG=1 and address 0: returns 0.
  - BYPASS=1 and an effective write targets the read address this cycle: returns that write data, B taking precedence over A.
  - Otherwise: returns the stored value.
- dbg_data always returns the stored value, or 0 for address 0 when ZERO_REG=1.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE→CLEAR on clr_req=1; the index counter loads 0.
  - CLEAR: writes 0 to register[index] each cycle, then index+1. Transitions to DONE after writing index DEPTH-1.
  - DONE: clr_done=1 for one cycle, then IDLE.
- clr_busy=1 in CLEAR only.
- While clr_busy=1, both write ports are ignored, with no conflict flag.
- While clr_busy=1, reads return stored values, so a partially cleared bank is visible.
- clr_req is ignored in CLEAR and DONE, and is level-sampled in IDLE only.

## Timing

- Reset (rst=0): all registers 0, FSM IDLE, index 0, clr_busy=0, clr_done=0, wr_conflict=0, immediately and asynchronously.
- With all registers 0 after reset, rd1/rd2/dbg_data read 0.
- Reset asserted mid-clear aborts the sequence. The result is the normal reset state.
- Write latency: stored on the rising edge; visible via stored-value read on the next cycle, or same cycle through bypass when BYPASS=1.
- Clear latency: clr_req sampled at edge N.
  - clr_busy high from N to N+DEPTH, i.e. DEPTH cycles.
  - clr_done high for the cycle after N+DEPTH.
  - Earliest new clr_req accepted at edge N+DEPTH+2.
  - A write presented in the DONE cycle is accepted.
- wr_conflict: registered, so it follows the conflicting cycle by exactly one cycle and holds for one cycle per conflicting cycle.
- Address-0 writes never produce a conflict when ZERO_REG=1.
- Index counter width is ADDR_W+1, so the terminal count is unambiguous.

## Test plan

- Reset, then write both ports: rst low then high; A writes x1=0x5A and B writes x2=0xA5 in the same cycle. Next cycle rd1(ra1=1)=0x5A, rd2(ra2=2)=0xA5, dbg_data(sel=2)=0xA5.
- Same-address conflict: A writes x3=0x11 and B writes x3=0x22 in the same cycle. Next cycle rd1(ra1=3)=0x22 and wr_conflict=1; the cycle after, wr_conflict=0.
- Bypass: BYPASS=1, x4 holds 0x07, B writes x4=0x99 with ra1=4. rd1=0x99 in the same cycle and dbg_data(sel=4)=0x07. Repeat with BYPASS=0: rd1=0x07 in the write cycle, 0x99 after.
- Zero register: ZERO_REG=1, A writes x0=0xFF. rd1(ra1=0)=0 in the same cycle and after, and wr_conflict stays 0 even if B also writes x0.
- Clear sequence: fill x1..x7 with nonzero values, pulse clr_req.
  - clr_busy stays high for 8 cycles.
  - x5 reads nonzero until the 6th busy cycle's edge.
  - clr_done pulses once; all registers then read 0.
  - A write attempted mid-clear is lost; clr_req during busy is ignored.
- Reset mid-clear: assert rst after 3 clear cycles. clr_busy→0 immediately, all registers 0, no clr_done pulse.
